resp_misr_capture: RTL and testbench

Sequential response compactor that sits directly downstream of the mapped combinational core. It accepts the core's 8 output bits (n6, n9, n42, n48, n56, n65, n68, n77) once per accepted pattern, folds them into a 16-bit MISR signature, and counts patterns. After a programmed number of patterns it flags done and compares the signature against a golden value. The core's outputs need no further handling beyond wiring them onto `resp`.

---
 rtl/resp_misr_capture.sv | 92 +++++++++
 tb/tb_resp_misr_capture.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/resp_misr_capture.sv
// Response compactor: folds 8-bit core responses into a 16-bit MISR signature over
// N_PAT accepted patterns, then flags done and compares against a golden signature.
module resp_misr_capture #(
  parameter int unsigned N_PAT = 256,
  parameter logic [15:0] SEED  = 16'h0000,
  parameter logic [15:0] POLY  = 16'h1021
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        resp_valid,
  input  logic [7:0]  resp,
  input  logic [15:0] golden,
  output logic        resp_ready,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic [15:0] sig,
  output logic [15:0] pat_cnt
);

  localparam logic [15:0] NPatW = 16'(N_PAT);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] sig_q, sig_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] sig_shift;
  logic [15:0] cnt_inc;

  assign sig_shift = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000);
  assign cnt_inc   = cnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    sig_d      = sig_q;
    cnt_d      = cnt_q;
    resp_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          sig_d   = SEED;
          cnt_d   = 16'd0;
        end
      end
      StRun: begin
        resp_ready = 1'b1;
        busy       = 1'b1;
        if (resp_valid) begin
          sig_d = sig_shift ^ {8'h00, resp};
          cnt_d = cnt_inc;
          // Leave on the same edge as the final accept.
          if (cnt_inc == NPatW) state_d = StDone;
        end
      end
      StDone: begin
        done = 1'b1;
        if (start) begin
          state_d = StRun;
          sig_d   = SEED;
          cnt_d   = 16'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sig_q   <= SEED;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sig     = sig_q;
  assign pat_cnt = cnt_q;
  assign match   = done && (sig_q == golden);

endmodule

// File: tb/tb_resp_misr_capture.sv
// Bench for resp_misr_capture: three instances with different N_PAT/SEED share stimulus;
// a queue-based reference model of the selected instance is checked every cycle.
module tb_resp_misr_capture;

  logic        clk = 1'b0;
  logic        rst, start, resp_valid;
  logic [7:0]  resp;
  logic [15:0] golden;

  logic        rdy1, bsy1, dn1, mt1, rdy2, bsy2, dn2, mt2, rdy4, bsy4, dn4, mt4;
  logic [15:0] sig1, cnt1, sig2, cnt2, sig4, cnt4;

  int          sel;
  logic        o_rdy, o_bsy, o_dn, o_mt;
  logic [15:0] o_sig, o_cnt;

  int          tests = 0;
  int          fails = 0;

  // Reference model: run phase plus the list of responses accepted this run.
  int          m_npat;
  logic [15:0] m_seed;
  int          mst;  // 0 idle, 1 run, 2 done
  logic [7:0]  acc[$];

  always #5 clk = ~clk;

  resp_misr_capture #(.N_PAT(1), .SEED(16'h8000), .POLY(16'h1021)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
    .golden(golden), .resp_ready(rdy1), .busy(bsy1), .done(dn1), .match(mt1),
    .sig(sig1), .pat_cnt(cnt1)
  );
  resp_misr_capture #(.N_PAT(2), .SEED(16'h0000), .POLY(16'h1021)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
    .golden(golden), .resp_ready(rdy2), .busy(bsy2), .done(dn2), .match(mt2),
    .sig(sig2), .pat_cnt(cnt2)
  );
  resp_misr_capture #(.N_PAT(4), .SEED(16'hBEEF), .POLY(16'h1021)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
    .golden(golden), .resp_ready(rdy4), .busy(bsy4), .done(dn4), .match(mt4),
    .sig(sig4), .pat_cnt(cnt4)
  );

  always_comb begin
    o_rdy = rdy2; o_bsy = bsy2; o_dn = dn2; o_mt = mt2; o_sig = sig2; o_cnt = cnt2;
    if (sel == 1) begin
      o_rdy = rdy1; o_bsy = bsy1; o_dn = dn1; o_mt = mt1; o_sig = sig1; o_cnt = cnt1;
    end else if (sel == 4) begin
      o_rdy = rdy4; o_bsy = bsy4; o_dn = dn4; o_mt = mt4; o_sig = sig4; o_cnt = cnt4;
    end
  end

  // Signature as repeated polynomial multiply-by-x modulo (x^16 + POLY), plus each response.
  function automatic logic [15:0] fold();
    int s = int'(m_seed);
    foreach (acc[i]) begin
      s = s * 2;
      if (s >= 65536) s = (s - 65536) ^ 32'h1021;
      s = s ^ int'(acc[i]);
    end
    return 16'(s);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      mst = 0;
      acc.delete();
    end else if (mst == 1) begin
      if (resp_valid) begin
        acc.push_back(resp);
        if (acc.size() == m_npat) mst = 2;
      end
    end else if (start) begin
      mst = 1;
      acc.delete();
    end
  endtask

  task automatic check_all();
    logic [15:0] es;
    es = fold();
    chk("sig", o_sig, es);
    chk("pat_cnt", o_cnt, 16'(acc.size()));
    chk("resp_ready", {15'b0, o_rdy}, {15'b0, mst == 1});
    chk("busy", {15'b0, o_bsy}, {15'b0, mst == 1});
    chk("done", {15'b0, o_dn}, {15'b0, mst == 2});
    chk("match", {15'b0, o_mt}, {15'b0, (mst == 2) && (es == golden)});
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic select(input int s, input int n, input logic [15:0] seed);
    sel    = s;
    m_npat = n;
    m_seed = seed;
    rst = 1'b1; start = 1'b0; resp_valid = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; resp_valid = 1'b0; resp = 8'h00; golden = 16'h0000;
    sel = 2; m_npat = 2; m_seed = 16'h0000; mst = 0;

    // Reset, then idle with valid responses that must be ignored.
    repeat (2) cycle();
    rst = 1'b0; resp_valid = 1'b1; resp = 8'hFF;
    repeat (5) begin
      cycle();
      chk("idle_sig", o_sig, 16'h0000);
      chk("idle_ready", {15'b0, o_rdy}, 16'h0000);
    end

    // Basic run, N_PAT=2.
    golden = 16'h0003; resp_valid = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0; resp_valid = 1'b1; resp = 8'h01;
    cycle();
    chk("basic_sig1", o_sig, 16'h0001);
    cycle();
    chk("basic_sig2", o_sig, 16'h0003);
    chk("basic_done", {15'b0, o_dn}, 16'h0001);
    chk("basic_match", {15'b0, o_mt}, 16'h0001);
    golden = 16'h0004;
    cycle();
    chk("basic_nomatch", {15'b0, o_mt}, 16'h0000);
    chk("basic_hold_cnt", o_cnt, 16'h0002);

    // Feedback path, N_PAT=1, SEED=8000.
    select(1, 1, 16'h8000);
    start = 1'b1;
    cycle();
    start = 1'b0; resp_valid = 1'b1; resp = 8'h00;
    cycle();
    chk("fb_sig", o_sig, 16'h1021);
    chk("fb_done", {15'b0, o_dn}, 16'h0001);

    // Gapped accepts, N_PAT=4, then back-to-back runs with start pulses mid-run.
    select(4, 4, 16'hBEEF);
    golden = 16'($urandom);
    start = 1'b1;
    cycle();
    for (int run = 0; run < 4; run++) begin
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        resp_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          resp = 8'($urandom);
          start = (k == 2);
          cycle();
        end
        start = 1'b0; resp_valid = 1'b1; resp = 8'($urandom);
        cycle();
      end
      chk("gap_done", {15'b0, o_dn}, 16'h0001);
      resp_valid = 1'b1; resp = 8'($urandom);
      cycle();
      chk("gap_no5th", o_cnt, 16'h0004);
      if (run[0]) golden = fold();
      cycle();
      // Restart from DONE with valid asserted: nothing accepted on the start edge.
      start = 1'b1;
      cycle();
      chk("b2b_cnt", o_cnt, 16'h0000);
      chk("b2b_sig", o_sig, 16'hBEEF);
    end

    // Reset mid-run, coincident with start.
    start = 1'b0; resp_valid = 1'b1;
    repeat (2) begin
      resp = 8'($urandom);
      cycle();
    end
    rst = 1'b1; start = 1'b1;
    cycle();
    chk("rst_busy", {15'b0, o_bsy}, 16'h0000);
    chk("rst_sig", o_sig, 16'hBEEF);
    chk("rst_cnt", o_cnt, 16'h0000);
    rst = 1'b0;
    cycle();
    start = 1'b0;
    repeat (4) begin
      resp = 8'($urandom);
      cycle();
    end
    golden = fold();
    resp_valid = 1'b0;
    cycle();
    chk("fresh_match", {15'b0, o_mt}, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
